// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int DEFAULT_CHUNK = 8;

    // True when the operand width splits into a whole number of slices.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_slice.sv
// Combinational CHUNK-bit carry-lookahead slice. Every carry is built
// directly from generate/propagate terms and the slice carry-in, so no
// carry ripples from bit to bit inside the slice.
module cla_slice
    import cla_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;

    assign g = a & b;
    assign p = a | b;

    // Expanded lookahead: c[i+1] = OR_j ( g[j] & p[j+1..i] ) | ( p[0..i] & cin ).
    always_comb begin
        logic term;
        logic acc;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = acc | term;
        end
    end

    assign sum      = a ^ b ^ c[CHUNK-1:0];
    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: one CLA slice per stage with the carry
// registered between stages. The whole pipe advances together whenever the
// output slot is empty or being consumed, so bubbles are kept in place.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = DEFAULT_CHUNK,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  op_e              i_op,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
);

    localparam int STAGES = WIDTH / CHUNK;

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of CHUNK");
    end
    if (CHUNK < 2) begin : g_bad_chunk
        $error("pipelined_cla_adder: CHUNK must be at least 2");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ovf_q;
    logic             zero_q;

    assign en      = ~o_valid | i_ready;
    assign o_ready = en;

    // Subtraction is a + ~b + 1; the caller's carry-in only matters for ADD.
    assign b_eff   = (i_op == OP_SUB) ? ~i_b : i_b;
    assign cin_eff = (i_op == OP_SUB) ? 1'b1 : i_cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             in_valid;
        logic [WIDTH-1:0] in_a;
        logic [WIDTH-1:0] in_b;
        logic [WIDTH-1:0] in_sum;
        logic             in_carry;
        logic [TAG_W-1:0] in_tag;
        logic [CHUNK-1:0] slice_sum;
        logic             slice_cout;
        logic             slice_msb;
        logic [WIDTH-1:0] nxt_sum;
        logic             q_valid;
        logic [WIDTH-1:0] q_a;
        logic [WIDTH-1:0] q_b;
        logic [WIDTH-1:0] q_sum;
        logic             q_carry;
        logic [TAG_W-1:0] q_tag;
        logic             unused_stage;

        if (k == 0) begin : g_head
            assign in_valid = i_valid;
            assign in_a     = i_a;
            assign in_b     = b_eff;
            assign in_sum   = '0;
            assign in_carry = cin_eff;
            assign in_tag   = i_tag;
        end else begin : g_body
            assign in_valid = g_stage[k-1].q_valid;
            assign in_a     = g_stage[k-1].q_a;
            assign in_b     = g_stage[k-1].q_b;
            assign in_sum   = g_stage[k-1].q_sum;
            assign in_carry = g_stage[k-1].q_carry;
            assign in_tag   = g_stage[k-1].q_tag;
        end

        cla_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (in_a[k*CHUNK +: CHUNK]),
            .b        (in_b[k*CHUNK +: CHUNK]),
            .cin      (in_carry),
            .sum      (slice_sum),
            .cout     (slice_cout),
            .c_msb_in (slice_msb)
        );

        // Drop this stage's sum chunk into the partially built result.
        always_comb begin
            nxt_sum                      = in_sum;
            nxt_sum[k*CHUNK +: CHUNK]    = slice_sum;
        end

        // Stage register: everything moves one slot forward when the pipe advances.
        always_ff @(posedge clk) begin
            if (reset) begin
                q_valid <= 1'b0;
                q_a     <= '0;
                q_b     <= '0;
                q_sum   <= '0;
                q_carry <= 1'b0;
                q_tag   <= '0;
            end else if (en) begin
                q_valid <= in_valid;
                q_a     <= in_a;
                q_b     <= in_b;
                q_sum   <= nxt_sum;
                q_carry <= slice_cout;
                q_tag   <= in_tag;
            end
        end

        // Consumed operand chunks and inner-slice MSB carries are intentionally dropped.
        assign unused_stage = ^{in_a, in_b, slice_msb};
    end

    // Overflow and zero are decided alongside the final sum chunk and held with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            ovf_q  <= g_stage[STAGES-1].slice_msb ^ g_stage[STAGES-1].slice_cout;
            zero_q <= (g_stage[STAGES-1].nxt_sum == '0);
        end
    end

    logic unused_tail;
    assign unused_tail = ^{g_stage[STAGES-1].q_a, g_stage[STAGES-1].q_b};

    assign o_valid = g_stage[STAGES-1].q_valid;
    assign o_sum   = g_stage[STAGES-1].q_sum;
    assign o_cout  = g_stage[STAGES-1].q_carry;
    assign o_tag   = g_stage[STAGES-1].q_tag;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;

endmodule
